// File: rtl/tcm_boot_loader.sv
// Byte-stream boot loader: collects a length-prefixed image, writes it to ITCM (64-bit) and DTCM (32-bit),
// then releases the core reset. Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module tcm_boot_loader #(
    parameter int ITCM_SIZE = 16384,
    parameter int ITCM_AW   = 11,
    parameter int DTCM_AW   = 12
) (
    input  logic               clk,
    input  logic               cpurst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic               reload,
    output logic               itcm_we,
    output logic [ITCM_AW-1:0] itcm_addr,
    output logic [63:0]        itcm_wdata,
    output logic               dtcm_we,
    output logic [DTCM_AW-1:0] dtcm_addr,
    output logic [31:0]        dtcm_wdata,
    output logic               cpurst,
    output logic               load_done,
    output logic               load_err,
    output logic [31:0]        byte_cnt
);

    localparam logic [31:0] SIZE_BYTES = 32'(ITCM_SIZE);

    typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_FLUSH, S_RUN, S_ERR} state_t;

    state_t      state;
    logic [1:0]  hdr_cnt;
    logic [31:0] len_reg;
    logic [63:0] asm_reg;
    logic [63:0] asm_next;
    logic [31:0] hdr_len;
    logic [31:0] cnt_next;
    logic        is_final;
    logic        accept;
    logic        frame_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_reg;
`endif

    assign in_ready = cpurst_n && (state == S_LEN || state == S_DATA || state == S_CSUM);
    assign accept   = in_valid && in_ready;
    assign hdr_len  = {in_data, len_reg[23:0]};
    assign cnt_next = byte_cnt + 32'd1;
    assign is_final = (cnt_next == len_reg);

    always_comb begin
        asm_next = asm_reg;
        asm_next[{byte_cnt[2:0], 3'b000} +: 8] = in_data;
    end

    // Every way a frame can be malformed, evaluated on the byte being accepted.
    always_comb begin
        frame_err = 1'b0;
        if (accept) begin
            case (state)
                S_LEN: begin
                    if (hdr_cnt != 2'd3)
                        frame_err = in_last;
                    else if (hdr_len == 32'd0)
`ifdef LOADER_CHECKSUM_EN
                        frame_err = in_last;
`else
                        frame_err = !in_last;
`endif
                    else
                        frame_err = in_last || (hdr_len > SIZE_BYTES);
                end
`ifdef LOADER_CHECKSUM_EN
                S_DATA: frame_err = in_last;
                S_CSUM: frame_err = !in_last || (in_data != sum_reg);
`else
                S_DATA: frame_err = (in_last != is_final);
`endif
                default: frame_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state      <= S_LEN;
            hdr_cnt    <= 2'd0;
            len_reg    <= 32'd0;
            asm_reg    <= 64'd0;
            byte_cnt   <= 32'd0;
            itcm_we    <= 1'b0;
            itcm_addr  <= '0;
            itcm_wdata <= 64'd0;
            dtcm_we    <= 1'b0;
            dtcm_addr  <= '0;
            dtcm_wdata <= 32'd0;
            cpurst     <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg    <= 8'd0;
`endif
        end else begin
            itcm_we <= 1'b0;
            dtcm_we <= 1'b0;
            if (accept && state == S_DATA)
                byte_cnt <= cnt_next;
            if (frame_err) begin
                state    <= S_ERR;
                load_err <= 1'b1;
            end else begin
                case (state)
                    S_LEN: if (accept) begin
                        len_reg[{hdr_cnt, 3'b000} +: 8] <= in_data;
                        hdr_cnt <= hdr_cnt + 2'd1;
                        if (hdr_cnt == 2'd3) begin
                            if (hdr_len == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state     <= S_RUN;
                                cpurst    <= 1'b0;
                                load_done <= 1'b1;
`endif
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: if (accept) begin
                        // A completed 64-bit word leaves the assembly register clean for a later partial flush.
                        asm_reg <= (byte_cnt[2:0] == 3'd7) ? 64'd0 : asm_next;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg <= sum_reg + in_data;
`endif
                        if (byte_cnt[1:0] == 2'd3) begin
                            dtcm_we    <= 1'b1;
                            dtcm_addr  <= byte_cnt[DTCM_AW+1:2];
                            dtcm_wdata <= byte_cnt[2] ? asm_next[63:32] : asm_next[31:0];
                        end
                        if (byte_cnt[2:0] == 3'd7) begin
                            itcm_we    <= 1'b1;
                            itcm_addr  <= byte_cnt[ITCM_AW+2:3];
                            itcm_wdata <= asm_next;
                        end
                        if (is_final)
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_FLUSH;
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CSUM: if (accept) state <= S_FLUSH;
`endif
                    S_FLUSH: begin
                        if (byte_cnt[1:0] != 2'd0) begin
                            dtcm_we    <= 1'b1;
                            dtcm_addr  <= byte_cnt[DTCM_AW+1:2];
                            dtcm_wdata <= byte_cnt[2] ? asm_reg[63:32] : asm_reg[31:0];
                        end
                        if (byte_cnt[2:0] != 3'd0) begin
                            itcm_we    <= 1'b1;
                            itcm_addr  <= byte_cnt[ITCM_AW+2:3];
                            itcm_wdata <= asm_reg;
                        end
                        state     <= S_RUN;
                        cpurst    <= 1'b0;
                        load_done <= 1'b1;
                    end
                    S_RUN, S_ERR: if (reload) begin
                        state     <= S_LEN;
                        hdr_cnt   <= 2'd0;
                        len_reg   <= 32'd0;
                        asm_reg   <= 64'd0;
                        byte_cnt  <= 32'd0;
                        cpurst    <= 1'b1;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum_reg   <= 8'd0;
`endif
                    end
                    default: state <= S_ERR;
                endcase
            end
        end
    end

endmodule
